// File: rtl/dump_pkg.sv
// Shared types and helpers for the register dump UART: FSM states,
// frame geometry and the nibble-to-ASCII mapping.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    FIN
  } dump_state_t;

  localparam int NLINES         = 17;
  localparam int CHARS_PER_LINE = 10;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Uppercase hex digit: '0'..'9' then 'A'..'F' ('A' - 10 == 0x37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A byte is taken while idle or in the final cycle
// of a stop bit, so back-to-back bytes follow each other with no gap.
module uart_tx_byte
  import dump_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);

  dump_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          tick;

  assign tick  = (cnt == CNT_LAST);
  assign ready = (state == IDLE) || ((state == STOP) && tick);
  assign tx    = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  // The baud counter restarts on every state entry, so bit timing never drifts.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx_q;
    if (valid && ready) begin
      state_n   = START;
      cnt_n     = '0;
      bit_idx_n = '0;
      shreg_n   = data;
      tx_n      = 1'b0;
    end else begin
      case (state)
        START: begin
          if (tick) begin
            state_n = DATA;
            cnt_n   = '0;
            tx_n    = shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            cnt_n = '0;
            if (bit_idx == 3'd7) begin
              state_n = STOP;
              tx_n    = 1'b1;
            end else begin
              bit_idx_n = bit_idx + 3'd1;
              shreg_n   = {1'b0, shreg[7:1]};
              tx_n      = shreg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_dump_uart.sv
// Snapshots the 16 core registers plus PC on request and streams them as
// 17 lines of "XXXXXXXX\r\n" over an 8N1 UART.
module reg_dump_uart
  import dump_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][31:0] leds_registers,
  input  logic [31:0]       PC_led,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

  dump_state_t       state, state_n;
  logic [15:0][31:0] snap_regs;
  logic [31:0]       snap_pc;
  logic [4:0]        line_idx;
  logic [3:0]        char_idx;
  logic [31:0]       word;
  logic [2:0]        nib_sel;
  logic [3:0]        nib;
  logic [7:0]        char_byte;
  logic              last_byte;
  logic              valid;
  logic              ready;
  logic              accept;
  logic              busy_q;

  assign last_byte = (line_idx == 5'(NLINES - 1)) && (char_idx == 4'(CHARS_PER_LINE - 1));
  assign valid     = (state == LOAD);
  assign accept    = valid && ready;
  assign done      = (state == FIN);
  assign busy      = busy_q;

  // Character for the current (line, char) position; chars 8 and 9 end the line.
  always_comb begin
    word      = (line_idx == 5'(NLINES - 1)) ? snap_pc : snap_regs[line_idx[3:0]];
    nib_sel   = 3'd7 - char_idx[2:0];
    nib       = word[{nib_sel, 2'b00} +: 4];
    char_byte = hex_ascii(nib);
    if (char_idx == 4'd8) begin
      char_byte = CR;
    end else if (char_idx == 4'd9) begin
      char_byte = LF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // LOAD keeps offering the next character until the transmitter takes it;
  // STOP here means the last byte is in flight and we wait for its stop bit.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (accept && last_byte) state_n = STOP;
      STOP:    if (ready) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_regs <= '0;
      snap_pc   <= '0;
      line_idx  <= '0;
      char_idx  <= '0;
      busy_q    <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        snap_regs <= leds_registers;
        snap_pc   <= PC_led;
        line_idx  <= '0;
        char_idx  <= '0;
      end else if (accept) begin
        if (last_byte) begin
          line_idx <= '0;
          char_idx <= '0;
        end else if (char_idx == 4'(CHARS_PER_LINE - 1)) begin
          char_idx <= '0;
          line_idx <= line_idx + 5'd1;
        end else begin
          char_idx <= char_idx + 4'd1;
        end
      end
      if (accept) begin
        busy_q <= 1'b1;
      end else if ((state == STOP) && ready) begin
        busy_q <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .data  (char_byte),
    .valid (valid),
    .ready (ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: a frame-level model predicts tx/busy/done every
// cycle, and a UART monitor decodes bytes for literal line checks.
module tb_reg_dump_uart;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = 10;
  localparam int NBYTES = 170;
  localparam int FRAME  = NBYTES * 10 * DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              tx;
  logic [15:0][31:0] regs;
  logic [31:0]       pc;

  int          checks = 0;
  int          failures = 0;
  int          pos;
  int          cyc = 0;
  int          busy_rise_cyc = -1;
  int          done_cyc = -1;
  int          done_cnt = 0;
  logic        busy_prev = 1'b0;
  logic [31:0] exp_snap [17];
  logic [7:0]  rx_q [$];
  time         fall_q [$];
  logic        e_tx, e_busy, e_done;
  logic        a_bits [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  reg_dump_uart #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .leds_registers (regs),
    .PC_led         (pc),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .tx             (tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Expected byte idx of the frame, straight from the text format rules.
  function automatic logic [7:0] exp_byte(input int idx);
    int line, c, n;
    line = idx / 10;
    c    = idx % 10;
    if (c == 8) return 8'h0D;
    if (c == 9) return 8'h0A;
    n = int'((exp_snap[line] >> (4 * (7 - c))) & 32'hF);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  // Line level t cycles after the first start bit begins.
  function automatic logic exp_tx(input int t);
    int bi, ph;
    logic [7:0] b;
    bi = t / (10 * DIV);
    ph = (t % (10 * DIV)) / DIV;
    if (ph == 0) return 1'b0;
    if (ph == 9) return 1'b1;
    b = exp_byte(bi);
    return b[ph - 1];
  endfunction

  task automatic applyStimulus(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       regs[i] = 32'(i) * 32'h1111_1111;
        2:       regs[i] = 32'hFFFF_FFFF;
        default: regs[i] = $urandom;
      endcase
    end
    case (mode)
      0: begin regs[3] = 32'h0123_9ABF; pc = 32'hDEAD_BEEF; end
      2: pc = 32'hFFFF_FFFF;
      3: begin regs[2] = 32'h0; pc = $urandom; end
      default: pc = $urandom;
    endcase
  endtask

  task automatic checkLine(input string name, input int base, input string s);
    for (int i = 0; i < s.len(); i++) begin
      checkOutput(name, 32'(rx_q[base + i]), 32'(s[i]));
    end
  endtask

  task automatic waitPos(input int target);
    int n;
    n = 0;
    while (pos < target && n < FRAME + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_pos_reached", 32'(pos >= target), 32'd1);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done !== 1'b1 && n < FRAME + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: pos = cycles since the accepting edge; -1 when idle.
  initial begin
    pos = -1;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        pos = -1;
      end else if (pos < 0) begin
        if (start) begin
          for (int i = 0; i < 16; i++) exp_snap[i] = regs[i];
          exp_snap[16] = pc;
          pos = 0;
        end
      end else if (pos == FRAME + 1) begin
        pos = -1;
      end else begin
        pos++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    e_tx   = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (pos >= 1 && pos <= FRAME) begin
      e_busy = 1'b1;
      e_tx   = exp_tx(pos - 1);
    end else if (pos == FRAME + 1) begin
      e_done = 1'b1;
    end
    checkOutput("cycle_tx", 32'(tx), 32'(e_tx));
    checkOutput("cycle_busy", 32'(busy), 32'(e_busy));
    checkOutput("cycle_done", 32'(done), 32'(e_done));
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
    busy_prev = busy;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // UART monitor: samples every bit in the middle of its period.
  initial forever begin
    logic [7:0] b;
    @(negedge tx);
    fall_q.push_back($time);
    repeat (DIV / 2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1;
      b[i] = tx;
    end
    repeat (DIV) @(posedge clk);
    #1;
    rx_q.push_back(b);
  end

  initial begin
    #1_500_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Frame 1: known pattern, snapshot isolation, ignored starts.
    rx_q.delete();
    fall_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("model_r1_char", 32'(exp_byte(10)), 32'h31);
    checkOutput("model_cr", 32'(exp_byte(18)), 32'h0D);
    checkOutput("model_lf", 32'(exp_byte(19)), 32'h0A);
    checkOutput("model_hex_9", 32'(exp_byte(34)), 32'h39);
    checkOutput("model_hex_A", 32'(exp_byte(35)), 32'h41);
    checkOutput("model_hex_F", 32'(exp_byte(37)), 32'h46);
    checkOutput("model_pc_D", 32'(exp_byte(160)), 32'h44);
    checkOutput("model_A_start", 32'(exp_tx(162 * 10 * DIV + 5)), 32'd0);
    for (int b = 0; b < 8; b++) begin
      checkOutput("model_A_bit", 32'(exp_tx(162 * 10 * DIV + (b + 1) * DIV + 5)), 32'(a_bits[b]));
    end
    checkOutput("model_A_stop", 32'(exp_tx(162 * 10 * DIV + 9 * DIV + 5)), 32'd1);
    repeat (4) @(negedge clk);
    applyStimulus(2);
    waitPos(5001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_to_done", 32'(done_cyc - busy_rise_cyc), 32'(FRAME));
    repeat (20) @(negedge clk);
    checkOutput("idle_after_done_start", 32'(busy), 32'd0);
    checkOutput("done_count_1", 32'(done_cnt), 32'd1);
    checkOutput("rx_count_1", 32'(rx_q.size()), 32'(NBYTES));
    checkLine("line1", 10, "11111111");
    checkOutput("line1_cr", 32'(rx_q[18]), 32'h0D);
    checkOutput("line1_lf", 32'(rx_q[19]), 32'h0A);
    checkLine("line2_isolation", 20, "22222222");
    checkLine("line3_hex", 30, "01239ABF");
    checkLine("line16_pc", 160, "DEADBEEF");
    checkOutput("line16_cr", 32'(rx_q[168]), 32'h0D);
    checkOutput("line16_lf", 32'(rx_q[169]), 32'h0A);
    checkOutput("byte_A", 32'(rx_q[162]), 32'h41);
    checkOutput("byte_period_first", 32'((fall_q[1] - fall_q[0]) / 10), 32'd100);
    checkOutput("byte_period_last", 32'((fall_q[169] - fall_q[168]) / 10), 32'd100);

    // Frame 2: random values; start held over the done cycle and the next one.
    applyStimulus(1);
    rx_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    checkOutput("rx_count_2", 32'(rx_q.size()), 32'(NBYTES));
    applyStimulus(3);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    rx_q.delete();
    checkOutput("done_count_2", 32'(done_cnt), 32'd1 + 32'd1);
    @(negedge clk);
    checkOutput("restart_busy", 32'(busy), 32'd1);

    // Frame 3: abort with reset inside the first data bit of byte 20.
    waitPos(20 * 10 * DIV + 16);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_tx", 32'(tx), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("no_done_after_abort", 32'(done_cnt), 32'd2);

    // Frame 4: clean frame after the abort.
    applyStimulus(1);
    rx_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    repeat (10) @(negedge clk);
    checkOutput("done_count_4", 32'(done_cnt), 32'd3);
    checkOutput("rx_count_4", 32'(rx_q.size()), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++) begin
      checkOutput("frame4_byte", 32'(rx_q[i]), 32'(exp_byte(i)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
